// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD datapath and its operand feeder.
package gcd_pkg;

    localparam int unsigned GCD_WIDTH      = 16;
    localparam int unsigned GCD_PAIR_WIDTH = 2 * GCD_WIDTH;

    // Pairing state: waiting for a first word, or holding one and waiting for its partner.
    typedef enum logic [0:0] {
        StIdle   = 1'b0,
        StHaveHi = 1'b1
    } pack_state_e;

    // One operand pair as presented to the GCD input port.
    typedef struct packed {
        logic [GCD_WIDTH-1:0] hi;
        logic [GCD_WIDTH-1:0] lo;
    } gcd_pair_t;

endpackage

// File: rtl/gcd_operand_packer_if.sv
// Word-in / pair-out handshake bundle of the operand packer.
interface gcd_operand_packer_if
    import gcd_pkg::*;
#(
    parameter int unsigned WIDTH = GCD_WIDTH,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic               flush;
    logic               in_valid;
    logic [WIDTH-1:0]   in_data;
    logic               in_ready;
    logic               out_valid;
    logic [2*WIDTH-1:0] out_data;
    logic               out_ready;
    logic [CntW-1:0]    count;
    logic               pending;

    // Operand source and GCD consumer, seen from outside the packer.
    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count, pending
    );

    // The packer itself.
    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count, pending
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; storage is not reset, read data is zero when empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o & ~flush_i;
    assign do_pop  = pop_i & ~empty_o & ~flush_i;
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Storage write; no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/gcd_operand_packer.sv
// Pairs consecutive operand words into {first, second} and queues the pairs for the GCD.
module gcd_operand_packer
    import gcd_pkg::*;
#(
    parameter int unsigned WIDTH = GCD_WIDTH,
    parameter int unsigned DEPTH = 4
) (
    input logic                clk,
    input logic                reset,
    gcd_operand_packer_if.slave io
);
    pack_state_e      state_q;
    logic [WIDTH-1:0] hi_q;
    logic             in_fire, push;
    logic             fifo_full, fifo_empty;

    // In HAVE_HI the next word completes a pair, so it needs room in the FIFO. Only the
    // registered count is used, keeping out_ready off the in_ready path.
    assign io.in_ready  = ~io.flush & ((state_q == StIdle) | ~fifo_full);
    assign in_fire      = io.in_valid & io.in_ready;
    assign push         = in_fire & (state_q == StHaveHi);
    assign io.out_valid = ~fifo_empty & ~io.flush;
    assign io.pending   = (state_q == StHaveHi);

    // Pairing FSM: first word parks in hi_q, second word pushes the combined pair.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            hi_q    <= '0;
        end else if (io.flush) begin
            state_q <= StIdle;
        end else if (in_fire) begin
            if (state_q == StIdle) begin
                hi_q    <= io.in_data;
                state_q <= StHaveHi;
            end else begin
                state_q <= StIdle;
            end
        end
    end

    sync_fifo #(
        .WIDTH (2 * WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush_i (io.flush),
        .push_i  (push),
        .pop_i   (io.out_valid & io.out_ready),
        .wdata_i ({hi_q, io.in_data}),
        .rdata_o (io.out_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (io.count)
    );

endmodule
